// File: rtl/imem_rsp.sv
// imem_rsp: instruction-memory responder for the npc fetch interface.
// Accepts one fetch at a time, returns the word after LATENCY wait cycles,
// and flags misaligned or out-of-range addresses. A load port fills the
// word array and is active in every state, including during reset.
// Build option: IMEM_RSP_RANDLAT_EN adds 0..3 pseudo-random cycles of
// latency per request from a 16-bit LFSR reseeded by rst.
//
// Handshake rule, both channels: a transfer happens on a rising edge where
// valid and ready are both high. Once rsp_valid rises, rsp_inst/rsp_err stay
// stable until that transfer. req_ready is high only in IDLE, so a new
// request is never accepted in the same cycle a response is consumed.
module imem_rsp #(
  parameter int          DEPTH_LOG2 = 12,
  parameter int          LATENCY    = 2,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_inst,
  output logic                  rsp_err,
  input  logic                  ld_en,
  input  logic [DEPTH_LOG2-1:0] ld_addr,
  input  logic [31:0]           ld_data,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // Byte size of the mapped window; 33 bits so large depths cannot overflow.
  localparam logic [32:0] RANGE_BYTES = 33'd4 << DEPTH_LOG2;
  localparam int          NWORDS      = 1 << DEPTH_LOG2;

  state_e                state_q, state_d;
  logic [4:0]            cnt_q, cnt_d;
  logic [31:0]           addr_q, addr_d;
  logic [31:0]           inst_q;
  logic                  err_q;
  logic [31:0]           mem_q [0:NWORDS-1];

  logic                  rd_en;
  logic [31:0]           rd_addr;
  logic [31:0]           rd_off;
  logic                  rd_fault;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic [1:0]            lat_extra;
  logic [4:0]            wait_total;

`ifdef IMEM_RSP_RANDLAT_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic        lfsr_fb;

  // Fibonacci feedback for taps 16,14,13,11.
  always_comb begin
    lfsr_fb   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    lat_extra = lfsr_q[1:0];
  end

  // LFSR register, reseeded on reset so the latency sequence is repeatable.
  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= 16'hACE1;
    else     lfsr_q <= lfsr_d;
  end
`else
  // Fixed latency: no extra cycles.
  always_comb begin
    lat_extra = 2'b00;
  end
`endif

  // Total wait cycles for a request accepted this cycle.
  always_comb begin
    wait_total = 5'(LATENCY) + {3'b000, lat_extra};
  end

  // Address decode. In IDLE the read (LATENCY=0 case) uses the live request
  // address; in WAIT it uses the address latched at acceptance.
  always_comb begin
    rd_addr  = (state_q == S_IDLE) ? req_addr : addr_q;
    rd_off   = rd_addr - BASE_ADDR;
    rd_fault = (rd_addr[1:0] != 2'b00) || ({1'b0, rd_off} >= RANGE_BYTES);
    rd_idx   = rd_off[DEPTH_LOG2+1:2];
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    rd_en     = 1'b0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
`ifdef IMEM_RSP_RANDLAT_EN
    lfsr_d    = lfsr_q;
`endif
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d = req_addr;
`ifdef IMEM_RSP_RANDLAT_EN
          lfsr_d = {lfsr_q[14:0], lfsr_fb};
`endif
          if (wait_total == 5'd0) begin
            rd_en   = 1'b1;
            cnt_d   = 5'd0;
            state_d = S_RESP;
          end else begin
            cnt_d   = wait_total - 5'd1;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 5'd0) begin
          rd_en   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM state, wait counter and latched request address.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      addr_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  // Word array; the load port writes regardless of state or reset. A read on
  // the same edge sees the old word because the write lands after the edge.
  always_ff @(posedge clk) begin
    if (ld_en) mem_q[ld_addr] <= ld_data;
  end

  // Response register: captured once per request and held until consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_q <= 32'd0;
      err_q  <= 1'b0;
    end else if (rd_en) begin
      err_q  <= rd_fault;
      inst_q <= rd_fault ? 32'd0 : mem_q[rd_idx];
    end
  end

  assign rsp_inst  = inst_q;
  assign rsp_err   = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_imem_rsp.sv
// Directed testbench for imem_rsp (default parameters). Inputs are driven
// 1 ns after each rising edge and outputs are sampled at the same point.
module tb_imem_rsp;

  localparam int          DL2  = 12;
  localparam int          LAT  = 2;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid;
  logic            req_ready;
  logic [31:0]     req_addr;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [31:0]     rsp_inst;
  logic            rsp_err;
  logic            ld_en;
  logic [DL2-1:0]  ld_addr;
  logic [31:0]     ld_data;
  logic [1:0]      dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

`ifdef IMEM_RSP_RANDLAT_EN
  logic [15:0] lfsr_m;
`endif

  imem_rsp #(.DEPTH_LOG2(DL2), .LATENCY(LAT), .BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_inst  (rsp_inst),
    .rsp_err   (rsp_err),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .dbg_state (dbg_state)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // Reference latency for the next accepted request.
  function automatic int next_exp_lat();
    int l;
    l = LAT;
`ifdef IMEM_RSP_RANDLAT_EN
    l = l + int'(lfsr_m[1:0]);
    lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
`endif
    return l;
  endfunction

  task automatic model_reset();
`ifdef IMEM_RSP_RANDLAT_EN
    lfsr_m = 16'hACE1;
`endif
  endtask

  // Issue one request and wait (bounded) for rsp_valid. Optionally drive a
  // load-port write that lands on the same edge as the response read.
  task automatic fetch(input string tag, input logic [31:0] addr, input bit coll,
                       input logic [DL2-1:0] cidx, input logic [31:0] cdata);
    int exp_lat;
    int lat;
    exp_lat   = next_exp_lat();
    req_valid = 1'b1;
    req_addr  = addr;
    if (coll && exp_lat == 0) begin
      ld_en = 1'b1; ld_addr = cidx; ld_data = cdata;
    end
    check({tag, "_req_ready_idle"}, req_ready, 1);
    step();
    req_valid = 1'b0;
    ld_en     = 1'b0;
    req_addr  = $urandom;
    lat = 0;
    while (!rsp_valid && lat < 64) begin
      check({tag, "_req_ready_busy"}, req_ready, 0);
      if (coll && lat + 1 == exp_lat) begin
        ld_en = 1'b1; ld_addr = cidx; ld_data = cdata;
      end
      step();
      ld_en = 1'b0;
      lat++;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_rsp_valid"}, rsp_valid, 1);
    check({tag, "_req_ready_resp"}, req_ready, 0);
  endtask

  task automatic consume(input string tag);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check({tag, "_done_rsp_valid"}, rsp_valid, 0);
    check({tag, "_done_req_ready"}, req_ready, 1);
    check({tag, "_done_state"}, dbg_state, 0);
  endtask

  initial begin
    logic seen_valid;
    rst = 1'b1; req_valid = 1'b0; req_addr = 32'd0; rsp_ready = 1'b0;
    ld_en = 1'b0; ld_addr = '0; ld_data = 32'd0;
    model_reset();

    // Reset with array loads through the load port.
    step();
    step();
    ld_en = 1'b1; ld_addr = 12'd0;    ld_data = 32'h0010_0093; step();
    ld_addr = 12'd4095; ld_data = 32'h0010_0073; step();
    ld_addr = 12'd1;    ld_data = 32'hAAAA_AAAA; step();
    ld_en = 1'b0;
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_inst", rsp_inst, 32'h0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_state", dbg_state, 0);
    rst = 1'b0;
    step();

    // Basic fetch of word 0, then hold the response while req_addr toggles
    // and word 0 is overwritten.
    fetch("w0", 32'h8000_0000, 1'b0, '0, 32'h0);
    check("w0_inst", rsp_inst, 32'h0010_0093);
    check("w0_err", rsp_err, 0);
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1;
      req_addr  = $urandom;
      ld_en     = (i == 2);
      ld_addr   = 12'd0;
      ld_data   = 32'hDEAD_BEEF;
      step();
      ld_en = 1'b0;
      check("hold_rsp_valid", rsp_valid, 1);
      check("hold_rsp_inst", rsp_inst, 32'h0010_0093);
      check("hold_req_ready", req_ready, 0);
    end
    req_valid = 1'b0;
    consume("w0");

    // Fault cases.
    fetch("misalign", 32'h8000_0002, 1'b0, '0, 32'h0);
    check("misalign_err", rsp_err, 1);
    check("misalign_inst", rsp_inst, 32'h0);
    consume("misalign");

    fetch("above", 32'h8000_4000, 1'b0, '0, 32'h0);
    check("above_err", rsp_err, 1);
    check("above_inst", rsp_inst, 32'h0);
    consume("above");

    fetch("below", 32'h7FFF_FFFC, 1'b0, '0, 32'h0);
    check("below_err", rsp_err, 1);
    check("below_inst", rsp_inst, 32'h0);
    consume("below");

    fetch("last", 32'h8000_3FFC, 1'b0, '0, 32'h0);
    check("last_inst", rsp_inst, 32'h0010_0073);
    check("last_err", rsp_err, 0);
    consume("last");

    // Collision: write to word 1 on the read edge returns the old word.
    fetch("coll", 32'h8000_0004, 1'b1, 12'd1, 32'h5555_5555);
    check("coll_inst", rsp_inst, 32'hAAAA_AAAA);
    check("coll_err", rsp_err, 0);
    consume("coll");

    fetch("after_coll", 32'h8000_0004, 1'b0, '0, 32'h0);
    check("after_coll_inst", rsp_inst, 32'h5555_5555);
    consume("after_coll");

    // Reset while waiting: the pending response is dropped.
    req_valid = 1'b1;
    req_addr  = 32'h8000_0004;
    step();
    req_valid = 1'b0;
    check("rstw_in_wait", dbg_state, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    check("rstw_req_ready", req_ready, 1);
    check("rstw_rsp_valid", rsp_valid, 0);
    seen_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid) seen_valid = 1'b1;
      step();
    end
    check("rstw_no_late_rsp", seen_valid, 0);

    // New request after reset; array contents survive reset. rsp_ready is
    // held high throughout, which must not disturb the wait phase.
    rsp_ready = 1'b1;
    fetch("post_rst", 32'h8000_0000, 1'b0, '0, 32'h0);
    check("post_rst_inst", rsp_inst, 32'hDEAD_BEEF);
    check("post_rst_err", rsp_err, 0);
    step();
    rsp_ready = 1'b0;
    check("post_rst_done_valid", rsp_valid, 0);
    check("post_rst_done_ready", req_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
